// File: rtl/serial_frame_pkg.sv
// Shared types and line-level constants for the serial frame receiver.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } rx_state_e;

    localparam logic START_BIT  = 1'b1;
    localparam logic STOP_BIT   = 1'b0;
    localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/serial_frame_rx_if.sv
// Serial input, sample strobe and word-output handshake of the frame receiver.
interface serial_frame_rx_if #(parameter int unsigned DATA_W = 4);

    logic              serial_in;
    logic              bit_en;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic              frame_err;
    logic              overrun;

    modport slave (
        input  serial_in, bit_en, data_ready,
        output data_out, data_valid, frame_err, overrun
    );

    modport master (
        output serial_in, bit_en, data_ready,
        input  data_out, data_valid, frame_err, overrun
    );

endinterface

// File: rtl/frame_fifo2.sv
// Two-entry FIFO; the head register reads as zero whenever the FIFO is empty.
module frame_fifo2 #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem0_q, mem0_d;
    logic [W-1:0] mem1_q, mem1_d;
    logic [1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem0_q <= '0;
            mem1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            mem0_q <= mem0_d;
            mem1_q <= mem1_d;
            cnt_q  <= cnt_d;
        end
    end

    // Push while full without a pop is dropped here; the caller flags it.
    always_comb begin
        mem0_d = mem0_q;
        mem1_d = mem1_q;
        cnt_d  = cnt_q;
        case (cnt_q)
            2'd0: begin
                if (push) begin
                    mem0_d = din;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    mem0_d = din;
                end else if (pop) begin
                    mem0_d = '0;
                    cnt_d  = 2'd0;
                end else if (push) begin
                    mem1_d = din;
                    cnt_d  = 2'd2;
                end
            end
            default: begin
                if (push && pop) begin
                    mem0_d = mem1_q;
                    mem1_d = din;
                end else if (pop) begin
                    mem0_d = mem1_q;
                    mem1_d = '0;
                    cnt_d  = 2'd1;
                end
            end
        endcase
    end

    assign head  = mem0_q;
    assign full  = (cnt_q == 2'd2);
    assign empty = (cnt_q == 2'd0);

endmodule

// File: rtl/serial_frame_rx.sv
// Receives start/data/parity/stop frames from a serial line and buffers good
// words in a 2-entry FIFO with a valid/ready handshake.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter bit          PARITY = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    serial_frame_rx_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              par_q, par_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;

    logic              push_c;
    logic              pop_c;
    logic              good_c;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            par_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign pop_c  = ~empty & bus.data_ready;
    assign good_c = (bus.serial_in == STOP_BIT) &&
                    ((PARITY == 1'b0) || !(^{shreg_q, par_q}));

    // Frame FSM advances only on enabled edges; the error pulses default low.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        push_c      = 1'b0;
        if (bus.bit_en) begin
            case (state_q)
                IDLE: begin
                    if (bus.serial_in == START_BIT) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        shreg_d = '0;
                    end
                end
                DATA: begin
                    shreg_d = DATA_W'({shreg_q, bus.serial_in});
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = PARITY ? PAR : STOP;
                    end
                end
                PAR: begin
                    par_d   = bus.serial_in;
                    state_d = STOP;
                end
                default: begin
                    state_d = IDLE;
                    if (good_c) begin
                        push_c    = 1'b1;
                        overrun_d = full & ~pop_c;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    frame_fifo2 #(.W(DATA_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .pop   (pop_c),
        .din   (shreg_q),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    assign bus.data_out   = head;
    assign bus.data_valid = ~empty;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx with DATA_W=4, PARITY=1.
module tb_serial_frame_rx;
    import serial_frame_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    serial_frame_rx_if #(.DATA_W(4)) bus ();

    serial_frame_rx #(.DATA_W(4), .PARITY(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] data;
        logic       par;
        logic       stop;
        logic       exp_valid;
        logic [3:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Drive one bit, let one rising edge pass, return 1 time unit after it.
    task automatic tick(input logic b, input logic en);
        bus.serial_in = b;
        bus.bit_en    = en;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [3:0] d, input logic p, input logic s);
        tick(START_BIT, 1'b1);
        for (int i = 3; i >= 0; i--) tick(d[i], 1'b1);
        tick(p, 1'b1);
        tick(s, 1'b1);
    endtask

    task automatic check_out(input string name, input logic v, input logic [3:0] d,
                             input logic e, input logic o);
        check({name, ".valid"}, 32'(bus.data_valid), 32'(v));
        check({name, ".data"},  32'(bus.data_out),   32'(d));
        check({name, ".err"},   32'(bus.frame_err),  32'(e));
        check({name, ".ovr"},   32'(bus.overrun),    32'(o));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bus.serial_in  = IDLE_LEVEL;
        bus.bit_en     = 1'b0;
        bus.data_ready = 1'b1;

        vecs[0] = '{"good_b",  4'b1011, 1'b1, 1'b0, 1'b1, 4'hB, 1'b0};
        vecs[1] = '{"bad_par", 4'b1011, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1};
        vecs[2] = '{"bad_stp", 4'b1011, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1};
        vecs[3] = '{"good_0",  4'b0000, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0};
        vecs[4] = '{"good_f",  4'b1111, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0};
        vecs[5] = '{"bad_6",   4'b0110, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 4'h0, 1'b0, 1'b0);
        rst = 1'b0;
        tick(IDLE_LEVEL, 1'b1);

        // Table: consumer always ready, each word popped one edge after arrival.
        foreach (vecs[k]) begin
            send_frame(vecs[k].data, vecs[k].par, vecs[k].stop);
            check_out(vecs[k].name, vecs[k].exp_valid, vecs[k].exp_data, vecs[k].exp_err, 1'b0);
            tick(IDLE_LEVEL, 1'b1);
            check_out({vecs[k].name, "_after"}, 1'b0, 4'h0, 1'b0, 1'b0);
            tick(IDLE_LEVEL, 1'b1);
        end

        // Overrun: three good frames with the consumer stalled.
        bus.data_ready = 1'b0;
        send_frame(4'h3, 1'b0, 1'b0);
        send_frame(4'hA, 1'b0, 1'b0);
        check_out("full", 1'b1, 4'h3, 1'b0, 1'b0);
        send_frame(4'h5, 1'b0, 1'b0);
        check_out("ovr", 1'b1, 4'h3, 1'b0, 1'b1);
        tick(IDLE_LEVEL, 1'b1);
        check_out("ovr_pulse", 1'b1, 4'h3, 1'b0, 1'b0);
        bus.data_ready = 1'b1;
        tick(IDLE_LEVEL, 1'b1);
        check_out("pop1", 1'b1, 4'hA, 1'b0, 1'b0);
        tick(IDLE_LEVEL, 1'b1);
        check_out("pop2", 1'b0, 4'h0, 1'b0, 1'b0);

        // Full buffer, pop on the same edge a good frame completes.
        bus.data_ready = 1'b0;
        send_frame(4'h3, 1'b0, 1'b0);
        send_frame(4'hA, 1'b0, 1'b0);
        tick(START_BIT, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        bus.data_ready = 1'b1;
        tick(STOP_BIT, 1'b1);
        check_out("pushpop", 1'b1, 4'hA, 1'b0, 1'b0);
        tick(IDLE_LEVEL, 1'b1);
        check_out("pushpop_c", 1'b1, 4'hC, 1'b0, 1'b0);
        tick(IDLE_LEVEL, 1'b1);
        check_out("pushpop_e", 1'b0, 4'h0, 1'b0, 1'b0);

        // Bit_en toggling: disabled edges carry the inverted bit and must be ignored.
        begin
            logic [6:0] bits;
            bits = {START_BIT, 4'h6, 1'b0, STOP_BIT};
            for (int i = 6; i >= 0; i--) begin
                tick(~bits[i], 1'b0);
                if (i == 0) check_out("slow_pre", 1'b0, 4'h0, 1'b0, 1'b0);
                tick(bits[i], 1'b1);
            end
            check_out("slow", 1'b1, 4'h6, 1'b0, 1'b0);
            tick(IDLE_LEVEL, 1'b1);
        end

        // Async reset mid-frame with a word already buffered.
        bus.data_ready = 1'b0;
        send_frame(4'h3, 1'b0, 1'b0);
        tick(START_BIT, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_out("rst_mid", 1'b0, 4'h0, 1'b0, 1'b0);
        tick(1'b1, 1'b1);
        check_out("rst_hold", 1'b0, 4'h0, 1'b0, 1'b0);
        rst = 1'b0;
        send_frame(4'h9, 1'b0, 1'b0);
        check_out("post_rst", 1'b1, 4'h9, 1'b0, 1'b0);
        bus.data_ready = 1'b1;
        tick(IDLE_LEVEL, 1'b1);
        check_out("post_rst_e", 1'b0, 4'h0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Serial frame receiver that consumes the bit stream leaving the 4-bit shift register (`shift_out`) one bit per enabled clock. It detects a start bit, assembles DATA_W data bits MSB first, checks optional even parity and the stop bit, and presents completed words through a 2-entry output buffer with a valid/ready handshake. It is the stage directly downstream of the shift register and turns its serial output back into parallel words.

## Interface
- DATA_W, 4, data bits per frame (≥1)
- PARITY, 1, 1 = parity bit present (even parity over data), 0 = no parity bit
- CLK  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- Serial_in  input  1  serial bit stream (driven by the shift register's shift_out)
- Bit_en  input  1  sample strobe; Serial_in is consumed only on edges where Bit_en=1
- Data_out  output  DATA_W  word at head of buffer; 0 when buffer empty
- Data_valid  output  1  buffer non-empty
- Data_ready  input  1  consumer accepts head word on edge where Data_valid & Data_ready
- Frame_err  output  1  one-cycle pulse: parity or stop-bit error, frame discarded
- Overrun  output  1  one-cycle pulse: good frame completed while buffer full and no pop, frame discarded

## Operation
- Frame on line: idle 0, start bit 1, DATA_W data bits MSB first, parity bit (if PARITY), stop bit 0.
- FSM states IDLE, DATA, PAR, STOP; transitions only on edges with Bit_en=1:
  - IDLE: Serial_in=1 -> DATA, bit counter cleared; Serial_in=0 -> stay.
  - DATA: shift Serial_in into LSB of shift register; after DATA_W-th bit -> PAR if PARITY else STOP.
  - PAR: capture parity bit -> STOP.
  - STOP: evaluate frame -> IDLE (back-to-back start bit allowed on the next enabled edge).
- Frame good iff stop bit = 0 and (PARITY=0 or XOR of data bits and parity bit = 0).
- Good frame: pushed into buffer on the STOP edge. Bad frame: not pushed, Frame_err=1 for the following cycle.
- Buffer: 2 entries, FIFO order. Push and pop on the same edge always both succeed, including when full (no overrun). Push with buffer full and no pop -> word dropped, Overrun=1 for one cycle; buffer contents unchanged.
- Frame_err and Overrun never both high (a bad frame never checks fullness).
- Bit_en=0 freezes the FSM, counter and assembly register; handshake with the buffer continues normally.

## Timing
- Reset (asynchronous, any time including mid-frame): FSM=IDLE, counter=0, assembly register=0, buffer empty, Data_out=0, Data_valid=0, Frame_err=0, Overrun=0. Partial frame lost.
- Latency with Bit_en=1 every cycle: start bit sampled at edge N; stop bit sampled at edge N+DATA_W+1+PARITY; Data_valid high (buffer empty case) right after that edge, Data_out registered.
- Data_out/Data_valid change only on CLK edges; no combinational path from Serial_in or Data_ready to any output.
- Pop updates head on same edge; second entry (if any) appears immediately after.
- Maximum sustained rate: one frame per DATA_W+2+PARITY enabled edges.

## Structure
- Package serial_frame_pkg: FSM state enum (IDLE, DATA, PAR, STOP), frame bit constants (START_BIT=1, STOP_BIT=0, IDLE_LEVEL=0).
- Sub-module frame_fifo2: parameterised 2-entry FIFO (push, pop, full, empty, head data) used for the output buffer; receiver FSM, counter and checker in the top module.

## Test plan
- DATA_W=4, PARITY=1, Bit_en=1, Data_ready=1; Serial_in 1,1,0,1,1,1,0 -> Data_valid one cycle after 7th edge, Data_out=4'b1011, no error pulses.
- Same frame with parity bit 0 -> no push, Frame_err pulses once; stop bit 1 instead -> Frame_err pulses once.
- Data_ready=0, three good frames 4'h3, 4'hA, 4'h5 -> first two held in order, Overrun pulses on third; then pops return 3, A, empty.
- Buffer full, Data_ready=1 on the same edge a good frame 4'hC completes -> head popped, 4'hC pushed, no Overrun, Data_valid stays 1.
- Bit_en toggling 1/0 each cycle with frame 4'h6 -> identical Data_out=4'h6, completion at twice the edge count.
- Reset asserted after 2 data bits, released, then frame 4'h9 -> first frame lost, only 4'h9 delivered, all outputs 0 during reset.
